ir_cmd_ctrl: RTL

IR_CMD_CTRL -- requirements
Module: ir_cmd_ctrl

---
 rtl/ir_cmd_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/ir_cmd_ctrl.sv
// IR command controller: synchronizes the IR receiver's frame-ready level,
// validates and optionally filters each decoded frame, queues accepted
// commands in a small FIFO and exposes them over an Avalon-MM slave.
module ir_cmd_ctrl #(
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic        csi_clk,
   input  logic        csi_reset,
   input  logic        avs_chipselect,
   input  logic [3:0]  avs_address,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic        ins_irq,
   input  logic        coe_frame_valid,
   input  logic [31:0] coe_frame_data
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_CHECK, S_PUSH, S_DROP} state_t;

   // ---------------- frame_valid synchronizer ----------------
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [SYNC_STAGES-1:0] fill_q, fill_d;
   logic [SYNC_STAGES:0]   sync_ext, fill_ext;
   logic                   sync_prev_q, armed_q, armed_d;
   logic                   sync_out, new_frame;

   // Shift the raw level in; fill_q tracks when the chain holds post-reset samples.
   always_comb begin
      sync_ext  = {sync_q, coe_frame_valid};
      fill_ext  = {fill_q, 1'b1};
      sync_d    = sync_ext[SYNC_STAGES-1:0];
      fill_d    = fill_ext[SYNC_STAGES-1:0];
      sync_out  = sync_q[SYNC_STAGES-1];
      // Only arm edge detection once a real low has been seen, so a level held
      // high across reset does not look like a fresh frame.
      armed_d   = armed_q | (fill_q[SYNC_STAGES-1] & ~sync_out);
      new_frame = armed_q & sync_out & ~sync_prev_q;
   end

   // Synchronizer, edge-detect and arming flops.
   always_ff @(posedge csi_clk) begin
      if (csi_reset) begin
         sync_q      <= '0;
         fill_q      <= '0;
         sync_prev_q <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         fill_q      <= fill_d;
         sync_prev_q <= sync_out;
         armed_q     <= armed_d;
      end
   end

   // ---------------- control/status state ----------------
   logic [2:0]    ctrl_q, ctrl_d;
   logic [15:0]   addr_q, addr_d;
   logic          ovf_q, ovf_d, chkerr_q, chkerr_d;
   logic [7:0]    chk_cnt_q, chk_cnt_d, drop_cnt_q, drop_cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          irq_q, irq_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [23:0]   mem [FIFO_DEPTH];

   state_t        state_q;
   logic [31:0]   frame_q;

   // Capture FSM: a frame is latched, checked, then pushed or dropped.
   always_ff @(posedge csi_clk) begin
      if (csi_reset) begin
         state_q <= S_IDLE;
         frame_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE:    if (new_frame && ctrl_q[0]) state_q <= S_CAPTURE;
            S_CAPTURE: begin
               frame_q <= coe_frame_data;
               state_q <= S_CHECK;
            end
            S_CHECK: begin
               if (frame_q[31:24] != ~frame_q[23:16])          state_q <= S_IDLE;
               else if (ctrl_q[1] && frame_q[15:0] != addr_q)   state_q <= S_DROP;
               else                                             state_q <= S_PUSH;
            end
            S_PUSH:    state_q <= S_IDLE;
            S_DROP:    state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

   logic        empty, full, chk_fail, push_en, push_ovf, pop_en, wr_en, rd_en;
   logic [31:0] status;

   // FIFO flags and the per-cycle events raised by the FSM and the bus.
   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == CW'(FIFO_DEPTH));
      chk_fail = (state_q == S_CHECK) && (frame_q[31:24] != ~frame_q[23:16]);
      // A pop in this cycle does not free a slot for a push in the same cycle.
      push_en  = (state_q == S_PUSH) && !full;
      push_ovf = (state_q == S_PUSH) && full;
      wr_en    = avs_chipselect & avs_write;
      rd_en    = avs_chipselect & avs_read;
      pop_en   = rd_en && (avs_address == 4'd3) && !empty;
      status   = '0;
      status[0]         = empty;
      status[1]         = full;
      status[2]         = ovf_q;
      status[3]         = chkerr_q;
      status[8 +: CW]   = count_q;   // reaches bit 12 only for a 16-deep FIFO
   end

   // Next-state for registers, counters, pointers, read data and interrupt.
   always_comb begin
      ctrl_d     = ctrl_q;
      addr_d     = addr_q;
      ovf_d      = ovf_q;
      chkerr_d   = chkerr_q;
      chk_cnt_d  = chk_cnt_q;
      drop_cnt_d = drop_cnt_q;
      rdata_d    = rdata_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      irq_d      = ctrl_q[2] & (~empty | ovf_q | chkerr_q);

      if (wr_en) begin
         unique case (avs_address)
            4'd0: ctrl_d = avs_writedata[2:0];
            4'd1: addr_d = avs_writedata[15:0];
            4'd5: begin
               if (avs_writedata[2])  ovf_d    = 1'b0;
               if (avs_writedata[3])  chkerr_d = 1'b0;
               if (avs_writedata[31]) begin
                  chk_cnt_d  = '0;
                  drop_cnt_d = '0;
               end
            end
            default: ;
         endcase
      end

      // Error events take priority over a clear in the same cycle.
      if (chk_fail) begin
         chkerr_d = 1'b1;
         if (chk_cnt_d != 8'hFF) chk_cnt_d = chk_cnt_d + 8'd1;
      end
      if (push_ovf) begin
         ovf_d = 1'b1;
         if (drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
      end

      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_en, pop_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (rd_en) begin
         unique case (avs_address)
            4'd0:    rdata_d = {29'b0, ctrl_q};
            4'd1:    rdata_d = {16'b0, addr_q};
            4'd2:    rdata_d = status;
            4'd3:    rdata_d = pop_en ? {1'b1, 7'b0, mem[rd_ptr_q]} : 32'h0;
            4'd4:    rdata_d = {16'b0, drop_cnt_q, chk_cnt_q};
            default: rdata_d = 32'h0;
         endcase
      end
   end

   // Register bank.
   always_ff @(posedge csi_clk) begin
      if (csi_reset) begin
         ctrl_q     <= '0;
         addr_q     <= '0;
         ovf_q      <= 1'b0;
         chkerr_q   <= 1'b0;
         chk_cnt_q  <= '0;
         drop_cnt_q <= '0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         addr_q     <= addr_d;
         ovf_q      <= ovf_d;
         chkerr_q   <= chkerr_d;
         chk_cnt_q  <= chk_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage; contents are meaningless while empty so no reset needed.
   always_ff @(posedge csi_clk) begin
      if (push_en) mem[wr_ptr_q] <= {frame_q[23:16], frame_q[15:0]};
   end

   assign avs_readdata = rdata_q;
   assign ins_irq      = irq_q;

   logic unused_wdata;
   assign unused_wdata = ^avs_writedata[30:16];

endmodule
